// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES UART bytes, MSB-first, into one command word and hands it to
// a consumer through a level cmd_rdy/clr_cmd_rdy handshake. Stalled frames time out.
module uart_cmd_assembler #(
  parameter int NUM_BYTES    = 2,
  parameter int TIMEOUT_CLKS = 60000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   frame_err,
  output logic                   ovr_err
);

  localparam int CMD_W = 8 * NUM_BYTES;
  localparam int ASM_W = (NUM_BYTES > 1) ? 8 * (NUM_BYTES - 1) : 8;
  localparam int CNT_W = $clog2(NUM_BYTES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CLKS);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ASM_W-1:0]   asm_q, asm_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               frame_err_q, frame_err_d;
  logic               ovr_err_q, ovr_err_d;

  logic [ASM_W+7:0]   shifted;
  logic               complete;

  // Bytes gathered so far with the incoming byte appended in the LSBs.
  assign shifted = {asm_q, rx_data};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    timer_d     = timer_q;
    asm_d       = asm_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    frame_err_d = 1'b0;
    ovr_err_d   = 1'b0;
    complete    = 1'b0;
    clr_rx_rdy  = rx_rdy;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rx_rdy) begin
          asm_d      = shifted[ASM_W-1:0];
          byte_cnt_d = CNT_W'(1);
          if (NUM_BYTES == 1) complete = 1'b1;
          else                state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_rdy) begin
          // A byte arriving on the timeout cycle still belongs to the frame.
          asm_d      = shifted[ASM_W-1:0];
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          timer_d    = '0;
          if (byte_cnt_q == CNT_W'(NUM_BYTES - 1)) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
          frame_err_d = 1'b1;
          byte_cnt_d  = '0;
          asm_d       = '0;
          timer_d     = '0;
          state_d     = IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished frame loads only if the slot is free or being freed this edge.
    if (complete) begin
      byte_cnt_d = '0;
      asm_d      = '0;
      if (!cmd_rdy_q || clr_cmd_rdy) begin
        cmd_d     = shifted[CMD_W-1:0];
        cmd_rdy_d = 1'b1;
      end else begin
        ovr_err_d = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      timer_q     <= '0;
      asm_q       <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      timer_q     <= timer_d;
      asm_q       <= asm_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;
  assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: a frame-level reference model checked every
// cycle, plus directed scenarios with literal expected commands.
module tb_uart_cmd_assembler;

  localparam int NB = 2;
  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;
  logic        ovr_err;

  int checks = 0;
  int failures = 0;
  int clr_cnt = 0;
  int ferr_cnt = 0;
  int oerr_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_assembler #(.NUM_BYTES(NB), .TIMEOUT_CLKS(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frame_err   (frame_err),
    .ovr_err     (ovr_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collected bytes as a number, edge index of the last byte.
  typedef struct {
    logic [15:0] cmd;
    logic        rdy;
    logic        ferr;
    logic        oerr;
    int          n;
    logic [63:0] acc;
    int          cyc;
    int          last;
  } model_t;

  function automatic model_t step(input model_t m, input logic rdy_in,
                                  input logic [7:0] d, input logic clr);
    model_t r = m;
    r.ferr = 1'b0;
    r.oerr = 1'b0;
    r.cyc  = m.cyc + 1;
    if (clr) r.rdy = 1'b0;
    if (rdy_in) begin
      r.acc  = (m.acc << 8) | {56'd0, d};
      r.n    = m.n + 1;
      r.last = r.cyc;
      if (r.n == NB) begin
        if (!m.rdy || clr) begin
          r.cmd = r.acc[15:0];
          r.rdy = 1'b1;
        end else begin
          r.oerr = 1'b1;
        end
        r.n   = 0;
        r.acc = '0;
      end
    end else if (m.n > 0 && (r.cyc - m.last) == TO) begin
      r.ferr = 1'b1;
      r.n    = 0;
      r.acc  = '0;
    end
    return r;
  endfunction

  model_t m = '{default: 0};

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{default: 0};
    else     m <= step(m, rx_rdy, rx_data, clr_cmd_rdy);
  end

  always @(negedge clk) begin
    if (clr_rx_rdy) clr_cnt  <= clr_cnt + 1;
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (ovr_err)    oerr_cnt <= oerr_cnt + 1;
    check("clr_rx_rdy", clr_rx_rdy, rx_rdy);
    if (rst) begin
      check("rst_cmd", cmd, 0);
      check("rst_cmd_rdy", cmd_rdy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_ovr_err", ovr_err, 0);
    end else begin
      check("cmd", cmd, m.cmd);
      check("cmd_rdy", cmd_rdy, m.rdy);
      check("frame_err", frame_err, m.ferr);
      check("ovr_err", ovr_err, m.oerr);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Emulates UART_rx: rdy held until the edge on which it is consumed.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy  = 1'b0;
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
  endtask

  int c0, f0, o0;

  initial begin
    #1 rst = 1'b1;
    idle(3);
    check("lit_reset_cmd", cmd, 16'h0000);
    check("lit_reset_rdy", cmd_rdy, 0);
    rst = 1'b0;
    idle(2);

    // Two bytes 100 clocks apart.
    c0 = clr_cnt;
    send(8'hA5);
    idle(99);
    send(8'h3C);
    check("lit_t1_cmd", cmd, 16'hA53C);
    check("lit_t1_rdy", cmd_rdy, 1);
    check("lit_t1_clr_pulses", clr_cnt - c0, 2);
    ack();
    check("lit_ack_rdy", cmd_rdy, 0);
    check("lit_ack_cmd_kept", cmd, 16'hA53C);

    // Timeout on a partial frame, then a clean frame.
    f0 = ferr_cnt;
    send(8'h12);
    idle(TO + 5);
    check("lit_t2_ferr_pulses", ferr_cnt - f0, 1);
    check("lit_t2_rdy", cmd_rdy, 0);
    send(8'h34);
    idle(3);
    send(8'h56);
    check("lit_t2_cmd", cmd, 16'h3456);
    ack();

    // Overrun: second frame completes while the first is unacknowledged.
    o0 = oerr_cnt;
    send(8'h11);
    send(8'h11);
    check("lit_t3_first", cmd, 16'h1111);
    send(8'h22);
    send(8'h22);
    idle(2);
    check("lit_t3_ovr_pulses", oerr_cnt - o0, 1);
    check("lit_t3_cmd_kept", cmd, 16'h1111);
    check("lit_t3_rdy", cmd_rdy, 1);

    // Acknowledge on the completing edge: the new command loads.
    o0 = oerr_cnt;
    send(8'hBE);
    rx_data     = 8'hEF;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    idle(2);
    check("lit_t4_cmd", cmd, 16'hBEEF);
    check("lit_t4_rdy", cmd_rdy, 1);
    check("lit_t4_no_ovr", oerr_cnt - o0, 0);
    ack();

    // Second byte lands exactly on the timeout cycle.
    f0 = ferr_cnt;
    send(8'h77);
    idle(TO - 1);
    send(8'h88);
    idle(3);
    check("lit_t5_no_ferr", ferr_cnt - f0, 0);
    check("lit_t5_cmd", cmd, 16'h7788);
    check("lit_t5_rdy", cmd_rdy, 1);
    ack();

    // Reset mid-frame discards the partial byte.
    send(8'h99);
    idle(2);
    rst = 1'b1;
    idle(3);
    check("lit_t6_rst_cmd", cmd, 16'h0000);
    check("lit_t6_rst_rdy", cmd_rdy, 0);
    rst = 1'b0;
    idle(2);
    f0 = ferr_cnt;
    send(8'hCA);
    send(8'hFE);
    check("lit_t6_cmd", cmd, 16'hCAFE);
    idle(TO + 10);
    check("lit_t6_no_ferr", ferr_cnt - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
